// File: rtl/bilinear_interp_pipe.sv
// rtl/bilinear_interp_pipe.sv - three-stage bilinear pixel interpolator with stall and single-step control
module bilinear_interp_pipe #(
   parameter int PIX_W  = 8,
   parameter int FRAC_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step_mode,
   input  logic              step_pulse,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PIX_W-1:0]  p00,
   input  logic [PIX_W-1:0]  p10,
   input  logic [PIX_W-1:0]  p01,
   input  logic [PIX_W-1:0]  p11,
   input  logic [FRAC_W-1:0] fx,
   input  logic [FRAC_W-1:0] fy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_pix,
   output logic              busy,
   output logic [15:0]       pix_count
);

   // Weights are one bit wider than the fraction so a zero fraction gives the full weight 1.0.
   localparam int WGT_W = FRAC_W + 1;
   localparam int TOP_W = PIX_W + FRAC_W;
   localparam int V_W   = TOP_W + FRAC_W;
   localparam int RND_W = V_W + 1;
   localparam int SHIFT = 2 * FRAC_W;
   localparam logic [WGT_W-1:0] ONE  = {1'b1, {FRAC_W{1'b0}}};
   localparam logic [RND_W-1:0] HALF = RND_W'(1) << (SHIFT - 1);

   logic              s1_valid, s2_valid, s3_valid;
   logic [TOP_W-1:0]  s1_top, s1_bot;
   logic [FRAC_W-1:0] s1_fy;
   logic [V_W-1:0]    s2_v;
   logic [PIX_W-1:0]  s3_pix;
   logic              adv;

   logic [WGT_W-1:0]  wx, fx_w, wy, fy_w;
   logic [TOP_W-1:0]  top_next, bot_next;
   logic [V_W-1:0]    v_next;
   logic [RND_W-1:0]  v_rnd;
   logic [PIX_W-1:0]  pix_next;

   // Horizontal blend of both rows, vertical blend, then round-to-nearest back to pixel scale.
   assign fx_w     = {1'b0, fx};
   assign wx       = ONE - fx_w;
   assign fy_w     = {1'b0, s1_fy};
   assign wy       = ONE - fy_w;
   assign top_next = TOP_W'(p00) * TOP_W'(wx) + TOP_W'(p10) * TOP_W'(fx_w);
   assign bot_next = TOP_W'(p01) * TOP_W'(wx) + TOP_W'(p11) * TOP_W'(fx_w);
   assign v_next   = V_W'(s1_top) * V_W'(wy) + V_W'(s1_bot) * V_W'(fy_w);
   assign v_rnd    = RND_W'(s2_v) + HALF;
   assign pix_next = PIX_W'(v_rnd >> SHIFT);

   // Valid outputs are masked while reset is high so nothing can be handed off in the reset cycle.
   assign out_valid = s3_valid & ~rst;
   assign busy      = (s1_valid | s2_valid | s3_valid) & ~rst;
   assign out_pix   = s3_pix;
   assign adv       = (~step_mode | step_pulse) & ~(out_valid & ~out_ready);
   assign in_ready  = adv;

   // Whole pipeline shifts together on adv; data registers only load behind a valid beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         s1_top   <= '0;
         s1_bot   <= '0;
         s1_fy    <= '0;
         s2_v     <= '0;
         s3_pix   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
         if (in_valid) begin
            s1_top <= top_next;
            s1_bot <= bot_next;
            s1_fy  <= fy;
         end
         if (s1_valid) begin
            s2_v <= v_next;
         end
         if (s2_valid) begin
            s3_pix <= pix_next;
         end
      end
   end

   // Count completed output handshakes; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_count <= '0;
      end else if (out_valid & out_ready) begin
         pix_count <= pix_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_bilinear_interp_pipe.sv
// tb/tb_bilinear_interp_pipe.sv - randomized self-checking bench for bilinear_interp_pipe
module tb_bilinear_interp_pipe;

   logic        clk = 1'b0;
   logic        rst, step_mode, step_pulse, in_valid, in_ready;
   logic [7:0]  p00, p10, p01, p11, fx, fy;
   logic        out_valid, out_ready, busy;
   logic [7:0]  out_pix;
   logic [15:0] pix_count;

   int errors = 0;
   int checks = 0;

   // Reference: delay line of three slots plus a transfer counter.
   bit mv [3];
   int mp [3];
   int mcnt;

   int corner_vec [5][7] = '{
      '{10, 20, 30, 40, 8'h00, 8'h00, 10},
      '{10, 20, 30, 40, 8'hFF, 8'hFF, 40},
      '{10, 20, 30, 40, 8'h80, 8'h80, 25},
      '{255, 255, 255, 255, 8'h37, 8'hC1, 255},
      '{0, 255, 0, 255, 8'h80, 8'h00, 128}
   };

   bilinear_interp_pipe #(.PIX_W(8), .FRAC_W(8)) dut (
      .clk(clk), .rst(rst), .step_mode(step_mode), .step_pulse(step_pulse),
      .in_valid(in_valid), .in_ready(in_ready),
      .p00(p00), .p10(p10), .p01(p01), .p11(p11), .fx(fx), .fy(fy),
      .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
      .busy(busy), .pix_count(pix_count)
   );

   always #5 clk = ~clk;

   function automatic int ref_pix(int a, int b, int c, int d, int x, int y);
      int top, bot, v;
      top = a * (256 - x) + b * x;
      bot = c * (256 - x) + d * x;
      v   = top * (256 - y) + bot * y;
      return (v + 32768) / 65536;
   endfunction

   function automatic bit exp_valid();
      return mv[2] && !rst;
   endfunction

   function automatic bit exp_ready();
      return (!step_mode || step_pulse) && !(exp_valid() && !out_ready);
   endfunction

   function automatic bit exp_busy();
      return (mv[0] || mv[1] || mv[2]) && !rst;
   endfunction

   task automatic set_rand();
      p00 = 8'($urandom_range(0, 255));
      p10 = 8'($urandom_range(0, 255));
      p01 = 8'($urandom_range(0, 255));
      p11 = 8'($urandom_range(0, 255));
      fx  = 8'($urandom_range(0, 255));
      fy  = 8'($urandom_range(0, 255));
   endtask

   function automatic int cur_ref();
      return ref_pix(p00, p10, p01, p11, fx, fy);
   endfunction

   // Advance the reference by one clock using the current inputs, then move to just past the edge.
   task automatic tick();
      bit m_adv;
      m_adv = exp_ready();
      if (rst) begin
         mv   = '{default: 1'b0};
         mcnt = 0;
      end else begin
         if (exp_valid() && out_ready) mcnt = (mcnt + 1) % 65536;
         if (m_adv) begin
            mv[2] = mv[1]; mp[2] = mp[1];
            mv[1] = mv[0]; mp[1] = mp[0];
            mv[0] = in_valid;
            if (in_valid) mp[0] = cur_ref();
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; step_mode = 1; step_pulse = 0; in_valid = 1; out_ready = 0;
      set_rand();
      tick();
      tick();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL reset_in_ready got=%0b exp=%0b", in_ready, exp_ready()); end
      rst = 0; step_mode = 0; in_valid = 0; out_ready = 1;
      #1;
      checks++; if (pix_count !== 16'd0) begin errors++; $display("FAIL reset_pix_count got=%0d exp=0", pix_count); end
      checks++; if (out_pix !== 8'd0) begin errors++; $display("FAIL reset_out_pix got=%0d exp=0", out_pix); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_corners();
      step_mode = 0; step_pulse = 0; out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         p00 = 8'(corner_vec[i][0]); p10 = 8'(corner_vec[i][1]);
         p01 = 8'(corner_vec[i][2]); p11 = 8'(corner_vec[i][3]);
         fx  = 8'(corner_vec[i][4]); fy  = 8'(corner_vec[i][5]);
         in_valid = 1;
         tick();
         in_valid = 0;
         tick();
         #1;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL corner_early_valid vec=%0d got=%0b exp=0", i, out_valid); end
         tick();
         #1;
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL corner_latency vec=%0d got=%0b exp=1", i, out_valid); end
         checks++; if (out_pix !== 8'(corner_vec[i][6])) begin errors++; $display("FAIL corner_pix vec=%0d got=%0d exp=%0d", i, out_pix, corner_vec[i][6]); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int exp_arr [16];
      int k, base;
      step_mode = 0; step_pulse = 0; out_ready = 1; in_valid = 0;
      base = mcnt; k = 0;
      for (int cyc = 0; cyc < 22; cyc++) begin
         if (cyc < 16) begin
            set_rand(); in_valid = 1; exp_arr[cyc] = cur_ref();
         end else begin
            in_valid = 0;
         end
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cyc=%0d got=%0b exp=1", cyc, in_ready); end
         checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL stream_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_valid()); end
         if (out_valid === 1'b1) begin
            checks++;
            if (k >= 16 || cyc != k + 3 || out_pix !== 8'(exp_arr[k])) begin
               errors++; $display("FAIL stream_order cyc=%0d idx=%0d got=%0d exp=%0d", cyc, k, out_pix, (k < 16) ? exp_arr[k] : -1);
            end
            k++;
         end
         tick();
      end
      checks++; if (k != 16) begin errors++; $display("FAIL stream_count got=%0d exp=16", k); end
      checks++; if (pix_count !== 16'(base + 16)) begin errors++; $display("FAIL stream_pix_count got=%0d exp=%0d", pix_count, base + 16); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_backpressure();
      int exp_arr [3];
      int k;
      step_mode = 0; step_pulse = 0; k = 0;
      for (int cyc = 0; cyc < 13; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 7);
         if (cyc < 3) begin
            set_rand(); in_valid = 1; exp_arr[cyc] = cur_ref();
         end else if (cyc <= 7) begin
            set_rand(); in_valid = 1;
         end else begin
            in_valid = 0;
         end
         #1;
         checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ready()); end
         if (cyc >= 3 && cyc <= 7) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready cyc=%0d got=%0b exp=0", cyc, in_ready); end
            checks++; if (out_valid !== 1'b1 || out_pix !== 8'(exp_arr[0])) begin
               errors++; $display("FAIL bp_hold cyc=%0d valid=%0b got=%0d exp=%0d", cyc, out_valid, out_pix, exp_arr[0]);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (k >= 3 || cyc != k + 8 || out_pix !== 8'(exp_arr[k])) begin
               errors++; $display("FAIL bp_order cyc=%0d idx=%0d got=%0d exp=%0d", cyc, k, out_pix, (k < 3) ? exp_arr[k] : -1);
            end
            k++;
         end
         tick();
      end
      checks++; if (k != 3) begin errors++; $display("FAIL bp_count got=%0d exp=3", k); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_step();
      int e0;
      int eb [3];
      step_mode = 1; step_pulse = 0; out_ready = 0;
      set_rand(); in_valid = 1; e0 = cur_ref();
      for (int i = 0; i < 10; i++) begin
         #1;
         checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL step_idle cyc=%0d valid=%0b ready=%0b exp=0/0", i, out_valid, in_ready);
         end
         tick();
      end
      step_pulse = 1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL step_accept got=%0b exp=1", in_ready); end
      tick();
      step_pulse = 0; in_valid = 0;
      for (int i = 0; i < 3; i++) tick();
      step_pulse = 1; tick(); step_pulse = 0; tick(); tick();
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL step_two_pulses valid=%0b busy=%0b exp=0/1", out_valid, busy);
      end
      step_pulse = 1; tick(); step_pulse = 0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_pix !== 8'(e0)) begin
         errors++; $display("FAIL step_third_pulse valid=%0b got=%0d exp=%0d", out_valid, out_pix, e0);
      end
      step_pulse = 1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL step_bp_ready got=%0b exp=0", in_ready); end
      tick();
      step_pulse = 0;
      out_ready = 1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL step_pulse_forgotten got=%0b exp=0", in_ready); end
      out_ready = 0;
      tick();
      #1;
      checks++; if (out_valid !== 1'b1 || out_pix !== 8'(e0)) begin
         errors++; $display("FAIL step_bp_hold valid=%0b got=%0d exp=%0d", out_valid, out_pix, e0);
      end
      step_mode = 0; out_ready = 1;
      for (int i = 0; i < 4; i++) tick();
      step_mode = 1; step_pulse = 1; out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         set_rand(); in_valid = 1; eb[i] = cur_ref();
         tick();
      end
      step_pulse = 0; in_valid = 0; out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (out_valid !== 1'b1 || out_pix !== 8'(eb[0]) || busy !== 1'b1) begin
            errors++; $display("FAIL step_held valid=%0b busy=%0b got=%0d exp=%0d", out_valid, busy, out_pix, eb[0]);
         end
         tick();
      end
      step_mode = 0; out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step_pulse = 1'($urandom_range(0, 1));
         #1;
         checks++; if (out_valid !== 1'b1 || out_pix !== 8'(eb[i])) begin
            errors++; $display("FAIL step_drain idx=%0d valid=%0b got=%0d exp=%0d", i, out_valid, out_pix, eb[i]);
         end
         tick();
      end
      step_pulse = 0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL step_empty got=%0b exp=0", busy); end
   endtask

   task automatic test_random();
      step_mode = 0; step_pulse = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         set_rand();
         in_valid  = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 3) != 0);
         step_mode = 1'($urandom_range(0, 9) == 0);
         step_pulse = 1'($urandom_range(0, 1));
         #1;
         checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ready()); end
         checks++; if (out_valid !== exp_valid() || busy !== exp_busy()) begin
            errors++; $display("FAIL rand_valid cyc=%0d valid=%0b busy=%0b exp=%0b/%0b", cyc, out_valid, busy, exp_valid(), exp_busy());
         end
         if (exp_valid()) begin
            checks++; if (out_pix !== 8'(mp[2])) begin errors++; $display("FAIL rand_pix cyc=%0d got=%0d exp=%0d", cyc, out_pix, mp[2]); end
         end
         checks++; if (pix_count !== 16'(mcnt)) begin errors++; $display("FAIL rand_pix_count cyc=%0d got=%0d exp=%0d", cyc, pix_count, mcnt); end
         tick();
      end
      step_mode = 0; in_valid = 0; out_ready = 1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_reset_mid();
      step_mode = 0; step_pulse = 0; out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         set_rand(); in_valid = 1;
         tick();
      end
      rst = 1; set_rand();
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_during valid=%0b busy=%0b exp=0/0", out_valid, busy);
      end
      tick();
      rst = 0; in_valid = 0;
      #1;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_after valid=%0b busy=%0b exp=0/0", out_valid, busy);
      end
      checks++; if (pix_count !== 16'd0) begin errors++; $display("FAIL midrst_pix_count got=%0d exp=0", pix_count); end
      for (int i = 0; i < 4; i++) begin
         tick();
         #1;
         checks++; if (out_valid !== 1'b0 || pix_count !== 16'd0) begin
            errors++; $display("FAIL midrst_no_late cyc=%0d valid=%0b count=%0d exp=0/0", i, out_valid, pix_count);
         end
      end
   endtask

   initial begin
      rst = 1; step_mode = 0; step_pulse = 0; in_valid = 0; out_ready = 1;
      p00 = 0; p10 = 0; p01 = 0; p11 = 0; fx = 0; fy = 0;
      mv = '{default: 1'b0}; mp = '{default: 0}; mcnt = 0;
      #1;
      test_reset();
      test_corners();
      test_back_to_back();
      test_backpressure();
      test_step();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
